div8: RTL

DIV8 -- requirements
Module: div8

---
 rtl/div8_pkg.sv | 13 +
 rtl/div8_step.sv | 25 ++
 rtl/div8.sv | 131 +++++++++++++
 3 files changed

// File: rtl/div8_pkg.sv
// Shared definitions for the restoring divider: controller state encoding
// and the default operand width.
package div8_pkg;

    localparam int DIV8_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : div8_pkg

// File: rtl/div8_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor, keep or restore the partial remainder.
module div8_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_div,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);

    logic [WIDTH:0]   w_shifted;
    logic [WIDTH-1:0] w_diff;

    assign w_shifted = {i_rem, i_bit};

    // No-borrow test is done at WIDTH+1 bits. When it passes the true
    // difference is below the divisor, so the low WIDTH bits of the
    // subtraction are exact.
    assign o_qbit = (w_shifted >= {1'b0, i_div});
    assign w_diff = w_shifted[WIDTH-1:0] - i_div;
    assign o_rem  = o_qbit ? w_diff : w_shifted[WIDTH-1:0];

endmodule : div8_step

// File: rtl/div8.sv
// Iterative unsigned divider: one restoring step per clock, WIDTH steps per
// division, divide-by-zero short-cut straight to DONE.
module div8
    import div8_pkg::*;
#(
    parameter int WIDTH = DIV8_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             dz
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_aq;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_rem;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic             r_dz;

    logic             w_last;
    logic             w_qbit;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_aq_next;

    div8_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_rem  (r_rem),
        .i_bit  (r_aq[WIDTH-1]),
        .i_div  (r_b),
        .o_rem  (w_rem_next),
        .o_qbit (w_qbit)
    );

    // r_aq shifts dividend bits out of the top while quotient bits enter at
    // the bottom; after WIDTH steps it holds the full quotient.
    assign w_aq_next = {r_aq[WIDTH-2:0], w_qbit};
    assign w_last    = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b1;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_next = (b == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                busy         = 1'b0;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aq  <= '0;
            r_b   <= '0;
            r_rem <= '0;
            r_cnt <= '0;
            r_q   <= '0;
            r_r   <= '0;
            r_dz  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_aq  <= a;
                        r_b   <= b;
                        r_rem <= '0;
                        r_cnt <= '0;
                        if (b == '0) begin
                            r_q  <= '1;
                            r_r  <= a;
                            r_dz <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    r_aq  <= w_aq_next;
                    r_rem <= w_rem_next;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_q  <= w_aq_next;
                        r_r  <= w_rem_next;
                        r_dz <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign q  = r_q;
    assign r  = r_r;
    assign dz = r_dz;

endmodule : div8
